// File: rtl/postfix_evaluator.sv
// Postfix expression evaluator: fetches tokens from an external code ROM, decodes operands,
// drives a shared FP ALU and keeps an internal register stack. Optional PF_EVAL_MAX_DEPTH_EN adds max_depth.
module postfix_evaluator #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CODE_WIDTH  = 8,
    parameter int unsigned NUM_EXPR    = 4,
    parameter int unsigned PC_WIDTH    = 11,
    parameter int unsigned STACK_DEPTH = 64
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [$clog2(NUM_EXPR)-1:0]          expr_sel,
    output logic                                 busy,
    output logic [$clog2(NUM_EXPR)+PC_WIDTH-1:0] code_addr,
    input  logic [CODE_WIDTH-1:0]                code_data,
    output logic                                 decode_start,
    output logic [CODE_WIDTH-1:0]                decode_code,
    input  logic                                 decode_ready,
    input  logic [DATA_WIDTH-1:0]                decode_data,
    output logic                                 alu_start,
    output logic [2:0]                           alu_op,
    output logic [DATA_WIDTH-1:0]                operand_a,
    output logic [DATA_WIDTH-1:0]                operand_b,
    input  logic                                 alu_ready,
    input  logic [DATA_WIDTH-1:0]                alu_result,
    output logic [DATA_WIDTH-1:0]                result,
    output logic [2:0]                           error,
`ifdef PF_EVAL_MAX_DEPTH_EN
    output logic [$clog2(STACK_DEPTH+1)-1:0]     max_depth,
`endif
    output logic                                 done
);

    localparam int unsigned EXPR_W  = $clog2(NUM_EXPR);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W   = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        IDLE, FETCH, DISPATCH, DEC_WAIT, ALU_ISSUE, ALU_WAIT, FINISH, DONE
    } state_t;

    state_t                state;
    logic [EXPR_W-1:0]     expr_reg;
    logic [PC_WIDTH-1:0]   pc;
    logic [DEPTH_W-1:0]    depth;
    logic [2:0]            op_reg;
    logic [DATA_WIDTH-1:0] stack [STACK_DEPTH];

    logic [DEPTH_W-1:0]    depth_m1, depth_m2, depth_p1;
    logic [DATA_WIDTH-1:0] top, second;
    logic                  tok_end, tok_op;

    assign code_addr = {expr_reg, pc};
    assign depth_m1  = depth - DEPTH_W'(1);
    assign depth_m2  = depth - DEPTH_W'(2);
    assign depth_p1  = depth + DEPTH_W'(1);
    assign top       = stack[depth_m1[IDX_W-1:0]];
    assign second    = stack[depth_m2[IDX_W-1:0]];
    assign tok_end   = &code_data;
    assign tok_op    = (code_data[CODE_WIDTH-1 -: 2] == 2'b10);

    // Stack storage carries no reset; only the depth pointer defines valid entries.
    always_ff @(posedge clock) begin
        if (state == DEC_WAIT && decode_ready)
            stack[depth[IDX_W-1:0]] <= decode_data;
        else if (state == ALU_WAIT && alu_ready)
            stack[depth_m2[IDX_W-1:0]] <= alu_result;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            expr_reg     <= '0;
            pc           <= '0;
            depth        <= '0;
            op_reg       <= '0;
            busy         <= 1'b0;
            decode_start <= 1'b0;
            decode_code  <= '0;
            alu_start    <= 1'b0;
            alu_op       <= '0;
            operand_a    <= '0;
            operand_b    <= '0;
            result       <= '0;
            error        <= '0;
            done         <= 1'b0;
`ifdef PF_EVAL_MAX_DEPTH_EN
            max_depth    <= '0;
`endif
        end else begin
            decode_start <= 1'b0;
            alu_start    <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        expr_reg  <= expr_sel;
                        pc        <= '0;
                        depth     <= '0;
                        error     <= '0;
                        result    <= '0;
                        busy      <= 1'b1;
`ifdef PF_EVAL_MAX_DEPTH_EN
                        max_depth <= '0;
`endif
                        state     <= FETCH;
                    end
                end
                FETCH: state <= DISPATCH;
                DISPATCH: begin
                    pc <= pc + PC_WIDTH'(1);
                    // Every error exit raises done on entry to DONE so done and busy=0 coincide.
                    if (tok_end) begin
                        state <= FINISH;
                    end else if (&pc) begin
                        error <= 3'd4; done <= 1'b1; busy <= 1'b0; state <= DONE;
                    end else if (tok_op) begin
                        if (code_data[2:0] > 3'd4) begin
                            error <= 3'd5; done <= 1'b1; busy <= 1'b0; state <= DONE;
                        end else if (depth < DEPTH_W'(2)) begin
                            error <= 3'd1; done <= 1'b1; busy <= 1'b0; state <= DONE;
                        end else begin
                            op_reg <= code_data[2:0];
                            state  <= ALU_ISSUE;
                        end
                    end else if (depth == DEPTH_W'(STACK_DEPTH)) begin
                        error <= 3'd2; done <= 1'b1; busy <= 1'b0; state <= DONE;
                    end else begin
                        decode_start <= 1'b1;
                        decode_code  <= code_data;
                        state        <= DEC_WAIT;
                    end
                end
                DEC_WAIT: begin
                    if (decode_ready) begin
                        depth <= depth_p1;
`ifdef PF_EVAL_MAX_DEPTH_EN
                        if (depth_p1 > max_depth) max_depth <= depth_p1;
`endif
                        state <= FETCH;
                    end
                end
                ALU_ISSUE: begin
                    operand_a <= second;
                    if (op_reg == 3'd4) begin
                        operand_b <= {~top[DATA_WIDTH-1], top[DATA_WIDTH-2:0]};
                        alu_op    <= 3'b011;
                    end else begin
                        operand_b <= top;
                        alu_op    <= op_reg;
                    end
                    alu_start <= 1'b1;
                    state     <= ALU_WAIT;
                end
                ALU_WAIT: begin
                    if (alu_ready) begin
                        depth <= depth_m1;
                        state <= FETCH;
                    end
                end
                FINISH: begin
                    if (depth == DEPTH_W'(1)) begin
                        result <= top;
                        error  <= 3'd0;
                    end else begin
                        result <= '0;
                        error  <= 3'd3;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
